// File: rtl/keycode_event_scheduler.sv
// keycode_event_scheduler
// Turns the level-style keycode from the PIO into an ordered stream of
// press / release / typematic-repeat events, buffered in a small FWFT FIFO.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   keycode_in        : raw keycode (0 = no key)
//   evt_valid/ready   : head-of-FIFO handshake
//   evt_code/evt_type : head event (00 press, 01 release, 10 repeat)
//   held_code         : keycode currently tracked as held
//   fifo_count        : entries in the event FIFO
//   repeat_drop       : sticky flag, a repeat was lost to a full FIFO
//   clear_drop        : clears repeat_drop (a coincident set wins)
module keycode_event_scheduler #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DELAY_CYCLES = 25000000,
    parameter int unsigned RATE_CYCLES  = 5000000,
    parameter int unsigned CNT_W        = 25
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  keycode_in,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic [1:0]                  evt_type,
    output logic [7:0]                  held_code,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        repeat_drop,
    input  logic                        clear_drop
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_F = PTR_W + 1;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT_REL,
        S_EMIT_PRESS
    } state_t;

    state_t             state, state_n;
    logic [7:0]         kc_q;
    logic [7:0]         old_code, old_n, held_n;
    logic [CNT_W-1:0]   rep_cnt, cnt_n, limit_m1;
    logic               phase_rate, phase_n;

    logic [7:0]         mem_code [FIFO_DEPTH];
    logic [1:0]         mem_type [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;

    logic               push, pop, fifo_full, drop_set;
    logic [7:0]         push_code;
    logic [1:0]         push_type;

    assign fifo_full = (fifo_count == CNT_F'(FIFO_DEPTH));
    assign evt_valid = (fifo_count != '0);
    assign pop       = evt_valid & evt_ready;
    assign evt_code  = mem_code[rd_ptr];
    assign evt_type  = mem_type[rd_ptr];
    assign limit_m1  = phase_rate ? CNT_W'(RATE_CYCLES - 1) : CNT_W'(DELAY_CYCLES - 1);

    // State, key tracking and repeat counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            kc_q       <= '0;
            held_code  <= '0;
            old_code   <= '0;
            rep_cnt    <= '0;
            phase_rate <= 1'b0;
        end else begin
            state      <= state_n;
            kc_q       <= keycode_in;
            held_code  <= held_n;
            old_code   <= old_n;
            rep_cnt    <= cnt_n;
            phase_rate <= phase_n;
        end
    end

    // Next-state, event generation and repeat scheduling
    always_comb begin
        state_n   = state;
        held_n    = held_code;
        old_n     = old_code;
        cnt_n     = rep_cnt;
        phase_n   = phase_rate;
        push      = 1'b0;
        push_code = held_code;
        push_type = EVT_PRESS;
        drop_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (kc_q != held_code) begin
                    old_n   = held_code;
                    held_n  = kc_q;
                    cnt_n   = '0;
                    phase_n = 1'b0;
                    state_n = (held_code != '0) ? S_EMIT_REL : S_EMIT_PRESS;
                end else if (held_code != '0) begin
                    if (rep_cnt == limit_m1) begin
                        // Reload even when the repeat is discarded
                        cnt_n     = '0;
                        phase_n   = 1'b1;
                        push_type = EVT_REPEAT;
                        if (fifo_full) drop_set = 1'b1;
                        else           push     = 1'b1;
                    end else begin
                        cnt_n = rep_cnt + CNT_W'(1);
                    end
                end
            end
            S_EMIT_REL: begin
                push_code = old_code;
                push_type = EVT_RELEASE;
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_n = (held_code != '0) ? S_EMIT_PRESS : S_IDLE;
                end
            end
            S_EMIT_PRESS: begin
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // First-word-fall-through event FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_code[i] <= '0;
                mem_type[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_code[wr_ptr] <= push_code;
                mem_type[wr_ptr] <= push_type;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_F'(1);
                2'b01:   fifo_count <= fifo_count - CNT_F'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky repeat-drop flag; a new drop overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset)           repeat_drop <= 1'b0;
        else if (drop_set)   repeat_drop <= 1'b1;
        else if (clear_drop) repeat_drop <= 1'b0;
    end

endmodule

// File: tb/tb_keycode_event_scheduler.sv
// Testbench for keycode_event_scheduler: directed scenarios followed by
// randomized key activity, checked against a behavioural model and an
// event scoreboard.
module tb_keycode_event_scheduler;

    localparam int DEPTH = 4;
    localparam int DELAY = 8;
    localparam int RATE  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] keycode_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic [1:0] evt_type;
    logic [7:0] held_code;
    logic [2:0] fifo_count;
    logic       repeat_drop;
    logic       clear_drop;

    int n_cmp = 0;
    int n_bad = 0;

    keycode_event_scheduler #(
        .FIFO_DEPTH(DEPTH), .DELAY_CYCLES(DELAY), .RATE_CYCLES(RATE), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .keycode_in(keycode_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_type(evt_type),
        .held_code(held_code), .fifo_count(fifo_count),
        .repeat_drop(repeat_drop), .clear_drop(clear_drop)
    );

    always #5 clk = ~clk;

    // Behavioural model: key tracking and event queue
    localparam int M_IDLE = 0, M_REL = 1, M_PRESS = 2;
    logic [9:0] mq[$];     // model of what the FIFO holds
    logic [9:0] exp_q[$];  // scoreboard of events the consumer must see
    logic [7:0] m_kc = 0, m_held = 0, m_old = 0;
    int         m_mode = M_IDLE;
    int         m_since = 0;
    bit         m_rate = 0, m_drop = 0;

    always @(posedge clk) begin
        bit full, popq, put, dset;
        logic [9:0] ev;
        if (reset) begin
            m_kc = 0; m_held = 0; m_old = 0; m_mode = M_IDLE;
            m_since = 0; m_rate = 0; m_drop = 0;
            mq.delete(); exp_q.delete();
        end else begin
            full = (mq.size() >= DEPTH);
            popq = evt_ready && (mq.size() != 0);
            put = 0; dset = 0; ev = '0;
            if (m_mode == M_IDLE) begin
                if (m_kc != m_held) begin
                    m_mode  = (m_held != 0) ? M_REL : M_PRESS;
                    m_old   = m_held;
                    m_held  = m_kc;
                    m_since = 0;
                    m_rate  = 0;
                end else if (m_held != 0) begin
                    // a repeat is due once the key has sat for a full interval
                    m_since++;
                    if (m_since == (m_rate ? RATE : DELAY)) begin
                        m_since = 0;
                        m_rate  = 1;
                        if (full) dset = 1;
                        else begin put = 1; ev = {m_held, 2'b10}; end
                    end
                end
            end else if (m_mode == M_REL) begin
                if (!full) begin
                    put = 1; ev = {m_old, 2'b01};
                    m_mode = (m_held != 0) ? M_PRESS : M_IDLE;
                end
            end else begin
                if (!full) begin
                    put = 1; ev = {m_held, 2'b00};
                    m_mode = M_IDLE;
                end
            end
            if (popq) void'(mq.pop_front());
            if (put) begin mq.push_back(ev); exp_q.push_back(ev); end
            if (dset) m_drop = 1;
            else if (clear_drop) m_drop = 0;
            m_kc = keycode_in;
        end
    end

    // Monitor: status against model, head events against scoreboard
    always @(negedge clk) begin
        logic [9:0] e;
        n_cmp++;
        if (fifo_count != 3'(mq.size())) begin
            n_bad++; $display("FAIL fifo_count: got %0d want %0d at %0t", fifo_count, mq.size(), $time);
        end
        n_cmp++;
        if (held_code != m_held) begin
            n_bad++; $display("FAIL held_code: got %h want %h at %0t", held_code, m_held, $time);
        end
        n_cmp++;
        if (repeat_drop != m_drop) begin
            n_bad++; $display("FAIL repeat_drop: got %0b want %0b at %0t", repeat_drop, m_drop, $time);
        end
        n_cmp++;
        if (evt_valid != (mq.size() != 0)) begin
            n_bad++; $display("FAIL evt_valid: got %0b want %0b at %0t", evt_valid, mq.size() != 0, $time);
        end
        if (evt_valid && evt_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++; $display("FAIL event: got %h/%b want none at %0t", evt_code, evt_type, $time);
            end else begin
                e = exp_q.pop_front();
                if ({evt_code, evt_type} != e) begin
                    n_bad++;
                    $display("FAIL event: got %h/%b want %h/%b at %0t", evt_code, evt_type, e[9:2], e[1:0], $time);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++; $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // advance n clock edges, then settle just after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1; tick(2); reset = 0;
    endtask

    initial begin
        int hold;
        reset = 1; keycode_in = 0; evt_ready = 0; clear_drop = 0;
        tick(3); reset = 0;
        check("reset_count", fifo_count, 0);
        check("reset_held", held_code, 0);
        check("reset_valid", evt_valid, 0);

        // First press latency
        evt_ready = 1; tick(2);
        keycode_in = 8'h1A;
        tick(2);
        check("t1_held", held_code, 8'h1A);
        check("t1_valid_early", evt_valid, 0);
        tick(1);
        check("t1_valid", evt_valid, 1);
        check("t1_code", evt_code, 8'h1A);
        check("t1_type", evt_type, 0);

        // Change of key, then release
        keycode_in = 8'h04; tick(12);
        keycode_in = 8'h00; tick(10);

        // Held key with typematic repeat
        keycode_in = 8'h07; tick(30);
        keycode_in = 8'h00; tick(12);

        // Rapid changes with consumer stalled
        evt_ready = 0;
        keycode_in = 8'h01; tick(3);
        keycode_in = 8'h02; tick(3);
        keycode_in = 8'h03; tick(20);
        check("t4_full", fifo_count, DEPTH);
        evt_ready = 1; tick(3);
        evt_ready = 0; tick(20);
        check("t4_held", held_code, 8'h03);

        // Repeat dropped into a full FIFO, clear and coincident set/clear
        keycode_in = 8'h05; tick(30);
        check("t5_drop", repeat_drop, 1);
        check("t5_count", fifo_count, DEPTH);
        clear_drop = 1; tick(1); clear_drop = 0; tick(1);
        clear_drop = 1; tick(8); clear_drop = 0; tick(6);

        // Reset while emitting a release with three events queued
        do_reset();
        keycode_in = 8'h11; tick(6);
        keycode_in = 8'h12; tick(6);
        check("t6_queued", fifo_count, 3);
        keycode_in = 8'h2C; tick(2);
        reset = 1; tick(1);
        check("t6_count", fifo_count, 0);
        check("t6_held", held_code, 0);
        reset = 0; evt_ready = 1;
        tick(2);
        check("t6_valid_early", evt_valid, 0);
        tick(1);
        check("t6_valid", evt_valid, 1);
        check("t6_code", evt_code, 8'h2C);
        check("t6_type", evt_type, 0);
        tick(4);

        // Randomized key activity
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 4))
                0: keycode_in = 8'h00;
                1: keycode_in = 8'h01;
                2: keycode_in = 8'h1A;
                3: keycode_in = 8'h2C;
                default: keycode_in = 8'($urandom_range(1, 255));
            endcase
            hold = $urandom_range(1, 25);
            for (int c = 0; c < hold; c++) begin
                evt_ready  = ($urandom_range(0, 3) != 0);
                clear_drop = ($urandom_range(0, 15) == 0);
                reset      = ($urandom_range(0, 399) == 0);
                tick(1);
            end
        end
        reset = 0; clear_drop = 0;

        // Drain
        keycode_in = 0; evt_ready = 1; tick(40);
        check("drain_scoreboard", exp_q.size(), 0);
        check("drain_count", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
